ysyx_22051013_stage_skid_reg: RTL and testbench



---
 rtl/ysyx_22051013_stage_skid_reg_pkg.sv | 8 +
 rtl/ysyx_22051013_sat_cnt.sv | 17 +
 rtl/ysyx_22051013_stage_skid_reg.sv | 79 +++++++
 tb/tb_ysyx_22051013_stage_skid_reg.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051013_stage_skid_reg_pkg.sv
// ysyx_22051013_stage_skid_reg_pkg: occupancy-coded states shared by the stage register and its wrappers
package ysyx_22051013_stage_skid_reg_pkg;
  typedef enum logic [1:0] {
    SKR_EMPTY = 2'd0,
    SKR_ONE   = 2'd1,
    SKR_TWO   = 2'd2
  } skr_state_e;
endpackage

// File: rtl/ysyx_22051013_sat_cnt.sv
// ysyx_22051013_sat_cnt: saturating perf counter with increment and clear (clear wins)
module ysyx_22051013_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/ysyx_22051013_stage_skid_reg.sv
// ysyx_22051013_stage_skid_reg: valid/ready pipeline stage register with optional 2-entry skid buffer
module ysyx_22051013_stage_skid_reg
  import ysyx_22051013_stage_skid_reg_pkg::*;
#(
  parameter int DW       = 256,
  parameter bit SKID     = 1'b1,
  parameter bit CLR_DATA = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             clr_cnt
);
  skr_state_e    state_q, state_d;
  logic [DW-1:0] main_q, main_d, skid_q, skid_d;
  logic          in_ready_q, in_ready_d, in_fire, out_fire;
  assign out_valid = state_q != SKR_EMPTY;
  assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKR_EMPTY;
      main_d  = CLR_DATA ? '0 : main_q;
      skid_d  = CLR_DATA ? '0 : skid_q;
    end else begin
      unique case (state_q)
        SKR_EMPTY: if (in_fire) begin
          state_d = SKR_ONE;
          main_d  = in_data;
        end
        SKR_ONE: if (in_fire && out_fire) main_d = in_data;
          else if (in_fire) begin
            state_d = SKR_TWO;
            skid_d  = in_data;
          end else if (out_fire) state_d = SKR_EMPTY;
        SKR_TWO: if (out_fire) begin
          state_d = SKR_ONE;
          main_d  = skid_q;
        end
        default: state_d = SKR_EMPTY;
      endcase
    end
    in_ready_d = state_d != SKR_TWO;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= SKR_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  ysyx_22051013_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready),
    .clr (clr_cnt),
    .cnt (stall_cnt)
  );
endmodule

// File: tb/tb_ysyx_22051013_stage_skid_reg.sv
// tb_ysyx_22051013_stage_skid_reg: skid (SKID=1, CNT_W=4) and single-entry (SKID=0) stages against a queue model
`timescale 1ns/1ps
module tb_ysyx_22051013_stage_skid_reg;
  localparam int DW = 16;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, flush = 0, clr_cnt = 0;
  logic [DW-1:0] in_data = '0, out_data;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;
  logic in_valid0 = 0, in_ready0, out_valid0, out_ready0 = 0, flush0 = 0, clr0 = 0;
  logic [DW-1:0] in_data0 = '0, out_data0;
  logic [1:0] occupancy0;
  logic [7:0] stall_cnt0;
  ysyx_22051013_stage_skid_reg #(.DW(DW), .SKID(1'b1), .CLR_DATA(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt));
  ysyx_22051013_stage_skid_reg #(.DW(DW), .SKID(1'b0), .CLR_DATA(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .flush(flush0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0), .clr_cnt(clr0));
  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] mq[$], mq0[$];
  logic [DW-1:0] m_last, m_last0;
  logic m_rdy;
  int m_cnt, m_cnt0;
  task automatic model_reset();
    mq.delete(); mq0.delete();
    m_last = '0; m_last0 = '0; m_rdy = 1'b1; m_cnt = 0; m_cnt0 = 0;
  endtask
  function automatic logic [DW-1:0] exp_data();
    return mq.size() > 0 ? mq[0] : m_last;
  endfunction
  // Called with inputs settled; advances both models and DUTs by one edge, returns at the next negedge.
  task automatic cycle();
    bit inf, outf, stall, inf0, outf0, stall0;
    logic [DW-1:0] d, d0;
    inf = in_valid && m_rdy; outf = mq.size() > 0 && out_ready; stall = mq.size() > 0 && !out_ready;
    inf0 = in_valid0 && (mq0.size() == 0 || out_ready0); outf0 = mq0.size() > 0 && out_ready0;
    stall0 = mq0.size() > 0 && !out_ready0;
    d = in_data; d0 = in_data0;
    @(posedge clk);
    if (clr_cnt) m_cnt = 0; else if (stall && m_cnt < 15) m_cnt++;
    if (stall0 && m_cnt0 < 255) m_cnt0++;
    if (flush) begin
      mq.delete(); m_last = '0; m_rdy = 1'b1;
    end else begin
      if (outf) m_last = mq.pop_front();
      if (inf) mq.push_back(d);
      m_rdy = mq.size() < 2;
    end
    if (outf0) m_last0 = mq0.pop_front();
    if (inf0) mq0.push_back(d0);
    @(negedge clk);
  endtask
  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_skid: out_valid=%b occ=%0d stall=%0d in_ready=%b out_data=%h, required 0 0 0 1 0000",
               out_valid, occupancy, stall_cnt, in_ready, out_data);
    end
    n_cmp++;
    if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0 || stall_cnt0 !== 8'd0 || in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_noskid: out_valid=%b occ=%0d stall=%0d in_ready=%b, required 0 0 0 1",
               out_valid0, occupancy0, stall_cnt0, in_ready0);
    end
  endtask
  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = DW'(i);
      cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== DW'(i) || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_%0d: out_valid=%b out_data=%h in_ready=%b, required 1 %h 1", i, out_valid, out_data, in_ready, DW'(i));
      end
    end
    in_valid = 0;
    cycle();
    n_cmp++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL stream_end: out_valid=%b stall=%0d, required 0 0", out_valid, stall_cnt);
    end
  endtask
  task automatic test_skid();
    out_ready = 0;
    in_valid = 1; in_data = 16'hA5A5; cycle();
    in_data = 16'h5A5A; cycle();
    in_valid = 0;
    n_cmp++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hA5A5) begin
      n_err++;
      $display("FAIL skid_full: occ=%0d in_ready=%b out_data=%h, required 2 0 a5a5", occupancy, in_ready, out_data);
    end
    cycle();
    n_cmp++;
    if (out_data !== 16'hA5A5 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL skid_hold: out_valid=%b out_data=%h, required 1 a5a5", out_valid, out_data);
    end
    out_ready = 1; cycle();
    n_cmp++;
    if (out_data !== 16'h5A5A || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_err++;
      $display("FAIL skid_drain1: out_data=%h in_ready=%b occ=%0d, required 5a5a 1 1", out_data, in_ready, occupancy);
    end
    cycle();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'(m_cnt)) begin
      n_err++;
      $display("FAIL skid_drain2: out_valid=%b occ=%0d stall=%0d, required 0 0 %0d", out_valid, occupancy, stall_cnt, m_cnt);
    end
  endtask
  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_data = 16'h1111; cycle();
    in_data = 16'h2222; cycle();
    in_data = 16'hCCCC; flush = 1; cycle();
    flush = 0; in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0 || in_ready !== 1'b1 || stall_cnt !== 4'(m_cnt)) begin
      n_err++;
      $display("FAIL flush_two: out_valid=%b occ=%0d out_data=%h in_ready=%b stall=%0d, required 0 0 0000 1 %0d",
               out_valid, occupancy, out_data, in_ready, stall_cnt, m_cnt);
    end
    out_ready = 1;
    repeat (3) begin
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_ghost: out_valid=%b out_data=%h, required 0", out_valid, out_data);
      end
    end
    out_ready = 0; in_valid = 1; in_data = 16'h3333; cycle();
    in_data = 16'hCCCC; flush = 1; cycle();
    flush = 0; in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
      n_err++;
      $display("FAIL flush_drop: out_valid=%b occ=%0d out_data=%h, required 0 0 0000", out_valid, occupancy, out_data);
    end
  endtask
  task automatic test_stall_sat();
    clr_cnt = 1; cycle(); clr_cnt = 0;
    out_ready = 0; in_valid = 1; in_data = 16'hD00D; cycle(); in_valid = 0;
    repeat (20) cycle();
    n_cmp++;
    if (stall_cnt !== 4'd15 || out_data !== 16'hD00D) begin
      n_err++;
      $display("FAIL stall_sat: stall=%0d out_data=%h, required 15 d00d", stall_cnt, out_data);
    end
    clr_cnt = 1; cycle(); clr_cnt = 0;
    n_cmp++;
    if (stall_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL stall_clr: stall=%0d, required 0", stall_cnt);
    end
    cycle();
    n_cmp++;
    if (stall_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL stall_resume: stall=%0d, required 1", stall_cnt);
    end
    out_ready = 1; cycle();
  endtask
  task automatic test_noskid();
    int acc = 0, del = 0;
    logic [DW-1:0] exp_out = 16'd1;
    bit fired;
    in_valid0 = 1; in_data0 = 16'd1;
    for (int i = 0; i < 60; i++) begin
      out_ready0 = 1'($urandom_range(1));
      #1;
      n_cmp++;
      if (in_ready0 !== (!out_valid0 || out_ready0) || in_ready0 !== (mq0.size() == 0 || out_ready0)) begin
        n_err++;
        $display("FAIL noskid_ready_%0d: in_ready=%b out_valid=%b out_ready=%b, required %b",
                 i, in_ready0, out_valid0, out_ready0, mq0.size() == 0 || out_ready0);
      end
      n_cmp++;
      if (occupancy0 !== 2'(mq0.size()) || occupancy0 > 2'd1) begin
        n_err++;
        $display("FAIL noskid_occ_%0d: occ=%0d, required %0d", i, occupancy0, mq0.size());
      end
      if (out_valid0 && out_ready0) begin
        n_cmp++;
        if (out_data0 !== exp_out) begin
          n_err++;
          $display("FAIL noskid_order_%0d: out_data=%h, required %h", i, out_data0, exp_out);
        end
        exp_out++; del++;
      end
      fired = in_valid0 && (mq0.size() == 0 || out_ready0);
      cycle();
      if (fired) begin
        acc++; in_data0 = in_data0 + 16'd1;
      end
    end
    in_valid0 = 0;
    n_cmp++;
    if (acc !== del + int'(occupancy0) || del < 10) begin
      n_err++;
      $display("FAIL noskid_count: accepted=%0d delivered=%0d occ=%0d, required accepted=delivered+occ", acc, del, occupancy0);
    end
    out_ready0 = 1; cycle(); out_ready0 = 0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(3) != 0);
      in_data = DW'($urandom);
      out_ready = 1'($urandom_range(2) != 0);
      flush = 1'($urandom_range(15) == 0);
      clr_cnt = 1'($urandom_range(31) == 0);
      cycle();
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size()) || in_ready !== m_rdy ||
          out_data !== exp_data() || stall_cnt !== 4'(m_cnt)) begin
        n_err++;
        $display("FAIL random_%0d: valid=%b occ=%0d rdy=%b data=%h stall=%0d, required %b %0d %b %h %0d",
                 i, out_valid, occupancy, in_ready, out_data, stall_cnt,
                 mq.size() > 0, mq.size(), m_rdy, exp_data(), m_cnt);
      end
    end
    in_valid = 0; flush = 0; clr_cnt = 0; out_ready = 1;
    repeat (2) cycle();
  endtask
  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_data = 16'h0A0A; cycle();
    in_data = 16'h0B0B; cycle(); in_valid = 0;
    n_cmp++;
    if (occupancy !== 2'd2 || stall_cnt === 4'd0) begin
      n_err++;
      $display("FAIL arst_pre: occ=%0d stall=%0d, required 2 nonzero", occupancy, stall_cnt);
    end
    #2 rst = 0;
    #1;
    model_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL arst_now: out_valid=%b occ=%0d stall=%0d in_ready=%b, required 0 0 0 1",
               out_valid, occupancy, stall_cnt, in_ready);
    end
    @(negedge clk); rst = 1;
    out_ready = 1; in_valid = 1; in_data = 16'h0E0E; cycle(); in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h0E0E || occupancy !== 2'd1) begin
      n_err++;
      $display("FAIL arst_resume: out_valid=%b out_data=%h occ=%0d, required 1 0e0e 1", out_valid, out_data, occupancy);
    end
    cycle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1;
    @(negedge clk);
    test_stream();
    test_skid();
    test_flush();
    test_stall_sat();
    test_noskid();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
